// File: rtl/flexbus_pkg.sv
// flexbus_pkg: shared FlexBus word geometry, default decode constants and bus-cycle state encoding
package flexbus_pkg;
  localparam int FB_WORD_W = 32;
  localparam int FB_LANES = 4;
  localparam logic [31:0] FB_BASE_ADDR = 32'h6000_0000;
  localparam logic [31:0] FB_BASE_MASK = 32'hF000_0000;
  typedef enum logic [1:0] {IDLE, SEL, WRITE, READ} fb_state_e;
endpackage

// File: rtl/flexbus_byte_reg.sv
// flexbus_byte_reg: 32-bit register with per-byte-lane write enables and a reset value
module flexbus_byte_reg
  import flexbus_pkg::*;
#(
  parameter logic [FB_WORD_W-1:0] RST_VAL = '0
) (
  input  logic                 FB_CLK,
  input  logic                 RST_n,
  input  logic                 we,
  input  logic [FB_LANES-1:0]  be,
  input  logic [FB_WORD_W-1:0] d,
  output logic [FB_WORD_W-1:0] q
);
  // update only the enabled lanes on a write, falling-edge clocked like the rest of the bus logic
  always_ff @(negedge FB_CLK or negedge RST_n)
    if (!RST_n) q <= RST_VAL;
    else if (we)
      for (int b = 0; b < FB_LANES; b++)
        if (be[b]) q[8*b +: 8] <= d[8*b +: 8];
endmodule

// File: rtl/flexbus_regbank.sv
// flexbus_regbank: parametrised FlexBus slave with RW control and RO status registers
module flexbus_regbank
  import flexbus_pkg::*;
#(
  parameter int          N_RW      = 8,
  parameter int          N_RO      = 4,
  parameter logic [31:0] BASE_ADDR = FB_BASE_ADDR,
  parameter logic [31:0] BASE_MASK = FB_BASE_MASK,
  parameter logic [31:0] RST_VAL   = 32'h0000_0000,
  parameter logic [31:0] UNMAP_VAL = 32'hDEAD_BEEF
) (
  input  logic                            FB_CLK,
  input  logic                            RST_n,
  input  logic                            FB_ALE,
  input  logic                            FB_CS,
  input  logic                            FB_RW,
  input  logic [3:0]                      FB_BE_n,
  inout  wire  [31:0]                     FB_AD,
  output logic [32*N_RW-1:0]              RW_REGS,
  input  logic [32*(N_RO>0?N_RO:1)-1:0]   RO_REGS,
  output logic [N_RW-1:0]                 WR_STB,
  output logic [N_RW+N_RO-1:0]            RD_STB
);
  localparam int N = N_RW + N_RO;
  localparam int AW = N > 1 ? $clog2(N) : 1;
  fb_state_e state, nxt;
  logic [31:0] addr_q, data_q, widx, rd_val;
  logic [N-1:0] hit;
  logic match, mapped_ok, wr_go, rd_go;
  assign match = (FB_AD & BASE_MASK) == (BASE_ADDR & BASE_MASK);
  assign widx = 32'(addr_q[AW+1:2]);
  assign mapped_ok = !(|((addr_q & ~BASE_MASK) >> (AW + 2))) && addr_q[1:0] == 2'b00;
  assign wr_go = state == SEL && !FB_ALE && !FB_CS && !FB_RW;
  assign rd_go = state == SEL && !FB_ALE && !FB_CS && FB_RW;
  assign FB_AD = (state == READ && !FB_CS && FB_RW && !FB_ALE) ? data_q : 'z;
  // decode the latched word index into a one-hot hit vector and the read data it selects
  always_comb begin
    rd_val = UNMAP_VAL;
    hit = '0;
    for (int k = 0; k < N_RW; k++)
      if (mapped_ok && widx == k) begin
        rd_val = RW_REGS[32*k +: 32];
        hit[k] = 1'b1;
      end
    for (int k = 0; k < N_RO; k++)
      if (mapped_ok && widx == N_RW + k) begin
        rd_val = RO_REGS[32*k +: 32];
        hit[N_RW+k] = 1'b1;
      end
  end
  // bus-cycle sequencing: ALE always restarts decode, the access happens on the edge that sees CS low
  always_comb begin
    nxt = state;
    if (FB_ALE) nxt = match ? SEL : IDLE;
    else if (state == SEL) nxt = FB_CS ? SEL : (FB_RW ? READ : WRITE);
    else if (state == WRITE || state == READ) nxt = FB_CS ? IDLE : state;
  end
  // state, address/data latches and single-cycle strobes
  always_ff @(negedge FB_CLK or negedge RST_n)
    if (!RST_n) begin
      state <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      WR_STB <= '0;
      RD_STB <= '0;
    end else begin
      state <= nxt;
      if (FB_ALE && match) addr_q <= FB_AD;
      if (rd_go) data_q <= rd_val;
      WR_STB <= wr_go ? hit[N_RW-1:0] : '0;
      RD_STB <= rd_go ? hit : '0;
    end
  for (genvar i = 0; i < N_RW; i++) begin : g_reg
    flexbus_byte_reg #(.RST_VAL(RST_VAL)) u_reg (
      .FB_CLK(FB_CLK),
      .RST_n (RST_n),
      .we    (wr_go && hit[i]),
      .be    (~FB_BE_n),
      .d     (FB_AD),
      .q     (RW_REGS[32*i +: 32])
    );
  end
endmodule

// File: tb/tb_flexbus_regbank.sv
// tb_flexbus_regbank: table-driven bus cycles plus hand-written abort and reset sequences
module tb_flexbus_regbank;
  logic clk = 1'b0, rst_n = 1'b0, ale = 1'b0, cs = 1'b0, rw = 1'b1, tb_oe = 1'b0;
  logic [3:0] be_n = 4'hF;
  logic [31:0] tb_dout = '0;
  wire  [31:0] fb_ad;
  logic [255:0] rw_regs;
  logic [127:0] ro_regs = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hCAFE_0001};
  logic [7:0] wr_stb;
  logic [11:0] rd_stb;
  int errors = 0, checks = 0;
  logic [31:0] model [8];

  typedef struct {
    bit rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] be_n;
    int reg_k;
    logic [31:0] exp;
    logic [7:0] exp_wr;
    logic [11:0] exp_rd;
  } vec_t;
  vec_t vecs[$];

  assign fb_ad = tb_oe ? tb_dout : 'z;
  for (genvar i = 0; i < 32; i++) begin : g_pu
    pullup (fb_ad[i]);
  end

  flexbus_regbank dut (
    .FB_CLK (clk),
    .RST_n  (rst_n),
    .FB_ALE (ale),
    .FB_CS  (cs),
    .FB_RW  (rw),
    .FB_BE_n(be_n),
    .FB_AD  (fb_ad),
    .RW_REGS(rw_regs),
    .RO_REGS(ro_regs),
    .WR_STB (wr_stb),
    .RD_STB (rd_stb)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bank(input string name);
    logic [255:0] t;
    for (int k = 0; k < 8; k++) begin
      t = rw_regs >> (32 * k);
      check32($sformatf("%s reg%0d", name, k), t[31:0], model[k]);
    end
  endtask

  function automatic vec_t mk(bit rd, logic [31:0] addr, logic [31:0] data, logic [3:0] be,
                              int reg_k, logic [31:0] exp, logic [7:0] exp_wr, logic [11:0] exp_rd);
    vec_t v;
    v.rd = rd; v.addr = addr; v.data = data; v.be_n = be;
    v.reg_k = reg_k; v.exp = exp; v.exp_wr = exp_wr; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic addr_phase(input logic [31:0] a);
    @(posedge clk);
    ale = 1'b1; cs = 1'b1; tb_oe = 1'b1; tb_dout = a;
    @(negedge clk);
  endtask

  task automatic write_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             output logic [7:0] s1, output logic [7:0] s2);
    addr_phase(a);
    @(posedge clk);
    ale = 1'b0; cs = 1'b0; rw = 1'b0; be_n = be; tb_dout = d;
    @(negedge clk); #1 s1 = wr_stb;
    @(negedge clk); #1 s2 = wr_stb;
    @(posedge clk);
    cs = 1'b1; rw = 1'b1; tb_oe = 1'b0; be_n = 4'hF;
    @(negedge clk);
  endtask

  task automatic read_cycle(input logic [31:0] a, output logic [31:0] d1, output logic [11:0] s1,
                            output logic [31:0] d2, output logic [11:0] s2);
    addr_phase(a);
    @(posedge clk);
    ale = 1'b0; tb_oe = 1'b0; cs = 1'b0; rw = 1'b1;
    @(negedge clk); #1 d1 = fb_ad; s1 = rd_stb;
    @(negedge clk); #1 d2 = fb_ad; s2 = rd_stb;
    @(posedge clk);
    cs = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d1, d2;
    logic [11:0] r1, r2;
    logic [7:0] w1, w2;
    vec_t v;
    vecs.push_back(mk(1, 32'h6000_0000, 32'h0,         4'hF, -1, 32'h0000_0000, 8'h00, 12'h001));
    vecs.push_back(mk(0, 32'h6000_0008, 32'h1234_5678, 4'h0,  2, 32'h1234_5678, 8'h04, 12'h000));
    vecs.push_back(mk(1, 32'h6000_0008, 32'h0,         4'hF, -1, 32'h1234_5678, 8'h00, 12'h004));
    vecs.push_back(mk(0, 32'h6000_0004, 32'hFFFF_FFFF, 4'h0,  1, 32'hFFFF_FFFF, 8'h02, 12'h000));
    vecs.push_back(mk(0, 32'h6000_0004, 32'h0000_00AA, 4'hE,  1, 32'hFFFF_FFAA, 8'h02, 12'h000));
    vecs.push_back(mk(0, 32'h6000_0004, 32'h5555_5555, 4'h5,  1, 32'h55FF_55AA, 8'h02, 12'h000));
    vecs.push_back(mk(1, 32'h6000_0020, 32'h0,         4'hF, -1, 32'hCAFE_0001, 8'h00, 12'h100));
    vecs.push_back(mk(0, 32'h6000_0020, 32'h0BAD_0BAD, 4'h0, -1, 32'h0,         8'h00, 12'h000));
    vecs.push_back(mk(0, 32'h6000_0FFC, 32'h0BAD_0BAD, 4'h0, -1, 32'h0,         8'h00, 12'h000));
    vecs.push_back(mk(1, 32'h6000_0100, 32'h0,         4'hF, -1, 32'hDEAD_BEEF, 8'h00, 12'h000));
    vecs.push_back(mk(1, 32'h6000_0030, 32'h0,         4'hF, -1, 32'hDEAD_BEEF, 8'h00, 12'h000));
    vecs.push_back(mk(1, 32'h6000_000A, 32'h0,         4'hF, -1, 32'hDEAD_BEEF, 8'h00, 12'h000));
    vecs.push_back(mk(0, 32'h6000_001C, 32'h1234_5678, 4'hF,  7, 32'h0000_0000, 8'h80, 12'h000));
    vecs.push_back(mk(0, 32'h6000_001C, 32'hA5A5_0F0F, 4'h0,  7, 32'hA5A5_0F0F, 8'h80, 12'h000));
    vecs.push_back(mk(1, 32'h6000_002C, 32'h0,         4'hF, -1, 32'h3333_0003, 8'h00, 12'h800));
    vecs.push_back(mk(0, 32'h7000_0004, 32'h0BAD_0BAD, 4'h0, -1, 32'h0,         8'h00, 12'h000));
    vecs.push_back(mk(1, 32'h7000_0004, 32'h0,         4'hF, -1, 32'hFFFF_FFFF, 8'h00, 12'h000));
    vecs.push_back(mk(1, 32'h6000_0004, 32'h0,         4'hF, -1, 32'h55FF_55AA, 8'h00, 12'h002));
    for (int k = 0; k < 8; k++) model[k] = 32'h0;

    #12;
    check_bank("reset");
    check32("reset wr_stb", 32'(wr_stb), 32'h0);
    check32("reset rd_stb", 32'(rd_stb), 32'h0);
    check32("reset bus released", fb_ad, 32'hFFFF_FFFF);
    cs = 1'b1;
    @(posedge clk);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      v = vecs[n];
      if (v.rd) begin
        read_cycle(v.addr, d1, r1, d2, r2);
        check32($sformatf("v%0d read data", n), d1, v.exp);
        check32($sformatf("v%0d read hold", n), d2, v.exp);
        check32($sformatf("v%0d rd_stb", n), 32'(r1), 32'(v.exp_rd));
        check32($sformatf("v%0d rd_stb end", n), 32'(r2), 32'h0);
      end else begin
        write_cycle(v.addr, v.data, v.be_n, w1, w2);
        if (v.exp_wr != 8'h00) model[v.reg_k] = v.exp;
        check32($sformatf("v%0d wr_stb", n), 32'(w1), 32'(v.exp_wr));
        check32($sformatf("v%0d wr_stb end", n), 32'(w2), 32'h0);
        check_bank($sformatf("v%0d", n));
      end
    end

    addr_phase(32'h6000_0000);
    @(posedge clk);
    cs = 1'b0; rw = 1'b0; be_n = 4'h0; tb_dout = 32'h7000_0000;
    @(negedge clk); #1
    check32("abort wr_stb", 32'(wr_stb), 32'h0);
    @(posedge clk);
    ale = 1'b0; tb_dout = 32'hBAD0_BAD0;
    @(negedge clk); #1
    check32("abort wr_stb late", 32'(wr_stb), 32'h0);
    check_bank("abort");
    @(posedge clk);
    cs = 1'b1; rw = 1'b1; tb_oe = 1'b0; be_n = 4'hF;
    @(negedge clk);

    addr_phase(32'h6000_0008);
    @(posedge clk);
    ale = 1'b0; tb_oe = 1'b0; cs = 1'b0; rw = 1'b1;
    @(negedge clk); #1
    check32("pre-reset drive", fb_ad, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1
    check32("reset releases bus", fb_ad, 32'hFFFF_FFFF);
    check32("reset rd_stb mid", 32'(rd_stb), 32'h0);
    for (int k = 0; k < 8; k++) model[k] = 32'h0;
    check_bank("mid reset");
    #2 rst_n = 1'b1;
    @(negedge clk); #1
    check32("idle after reset", fb_ad, 32'hFFFF_FFFF);
    @(posedge clk);
    cs = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
